// File: rtl/cpu_pc_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pc_pkg
// Shared definitions for the SM5xx program-counter / return-stack unit:
//   - pc_op_t    : operation code driven by the instruction decoder
//   - PL_MODE_*  : selects the Pl step function (binary or polynomial)
//   - PL_WIDTH   : width of the Pl (page-local) field, always the PC low bits
// ---------------------------------------------------------------------------
package cpu_pc_pkg;

  localparam int PL_WIDTH = 6;

  localparam int PL_MODE_BINARY = 0;
  localparam int PL_MODE_LFSR   = 1;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    STEP       = 3'd1,
    JUMP_SHORT = 3'd2,
    JUMP_LONG  = 3'd3,
    CALL       = 3'd4,
    RET        = 3'd5,
    ATPL       = 3'd6,
    SSR        = 3'd7
  } pc_op_t;

endpackage

// File: rtl/pc_stack_unit_if.sv
// ---------------------------------------------------------------------------
// pc_stack_unit_if
// Decoder <-> PC unit bundle.
//   Requests (decoder -> unit): en, op, addr, imm
//   Status   (unit -> decoder): pc, stack_top, level, in_subroutine, overflow
// master = instruction decoder side, slave = pc_stack_unit side.
// ---------------------------------------------------------------------------
interface pc_stack_unit_if
  import cpu_pc_pkg::*;
#(
  parameter int PC_WIDTH = 12
);

  logic                en;
  pc_op_t              op;
  logic [PC_WIDTH-1:0] addr;
  logic [PL_WIDTH-1:0] imm;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] stack_top;
  logic [3:0]          level;
  logic                in_subroutine;
  logic                overflow;

  modport master (
    output en, op, addr, imm,
    input  pc, stack_top, level, in_subroutine, overflow
  );

  modport slave (
    input  en, op, addr, imm,
    output pc, stack_top, level, in_subroutine, overflow
  );

endinterface

// File: rtl/pl_step.sv
// ---------------------------------------------------------------------------
// pl_step
// Purely combinational next-Pl function used by STEP.
//   pl_i : current Pl (PC low bits)
//   pl_o : Pl after one step
// PL_MODE_BINARY : plain increment, wrapping 0x3F -> 0x00.
// PL_MODE_LFSR   : SM510 polynomial counter, new MSB = XNOR of the two LSBs,
//                  remaining bits shift right.
// ---------------------------------------------------------------------------
module pl_step
  import cpu_pc_pkg::*;
#(
  parameter int PL_MODE = PL_MODE_LFSR
) (
  input  logic [PL_WIDTH-1:0] pl_i,
  output logic [PL_WIDTH-1:0] pl_o
);

  if (PL_MODE == PL_MODE_LFSR) begin : g_lfsr
    assign pl_o = {~(pl_i[1] ^ pl_i[0]), pl_i[PL_WIDTH-1:1]};
  end else begin : g_binary
    assign pl_o = pl_i + PL_WIDTH'(1);
  end

endmodule

// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
// Program counter and return stack for the SM5xx cores. One operation per
// enabled tick; every result is registered and visible after the clock edge.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : pc_stack_unit_if.slave (en/op/addr/imm in, pc/stack_top/level/
//           in_subroutine/overflow out)
// Stack entry 0 is the top. Push shifts toward the bottom and drops the
// oldest entry when full; pop shifts toward the top and leaves the bottom
// entry duplicated, as the silicon does.
// ---------------------------------------------------------------------------
module pc_stack_unit
  import cpu_pc_pkg::*;
#(
  parameter int                  PC_WIDTH    = 12,
  parameter int                  STACK_DEPTH = 2,
  parameter int                  PL_MODE     = PL_MODE_LFSR,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic            clk,
  input logic            reset,
  pc_stack_unit_if.slave bus
);

  if (PC_WIDTH < 10 || STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : g_bad_param
    $error("pc_stack_unit: PC_WIDTH must be >= 10 and STACK_DEPTH in 1..8");
  end

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam logic [3:0] DEPTH_LVL = 4'(STACK_DEPTH);

  pc_t                 pc_q, pc_d;
  pc_t                 stack_q [STACK_DEPTH];
  pc_t                 stack_d [STACK_DEPTH];
  logic [PL_WIDTH-1:0] pl_prev_q, pl_prev_d;
  logic [3:0]          level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [PL_WIDTH-1:0] pl_next;

  pl_step #(
    .PL_MODE(PL_MODE)
  ) u_pl_step (
    .pl_i(pc_q[PL_WIDTH-1:0]),
    .pl_o(pl_next)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    pc_d       = pc_q;
    stack_d    = stack_q;
    pl_prev_d  = pl_prev_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (bus.en) begin
      case (bus.op)
        STEP: begin
          // Only Pl advances; Pu/Pm never see a carry.
          pl_prev_d              = pc_q[PL_WIDTH-1:0];
          pc_d[PL_WIDTH-1:0]     = pl_next;
        end
        JUMP_SHORT: pc_d[PL_WIDTH-1:0] = bus.imm;
        JUMP_LONG:  pc_d = bus.addr;
        CALL: begin
          pc_d       = bus.addr;
          stack_d[0] = pc_q;
          for (int i = 1; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i-1];
          if (level_q < DEPTH_LVL) level_d = level_q + 4'd1;
          else                     overflow_d = 1'b1;
        end
        RET: begin
          // An empty-stack RET still pops: entry 0 is loaded, no flag raised.
          pc_d = stack_q[0];
          for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
          if (level_q != 4'd0) level_d = level_q - 4'd1;
        end
        // Page bits come from before the last STEP, so a Pl that stepped
        // across a 16-word boundary is pulled back into the original page.
        ATPL: pc_d[PL_WIDTH-1:0] = {pl_prev_q[5:4], bus.imm[3:0]};
        SSR:  stack_d[0][9:6]    = bus.imm[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (reset) begin
      pc_q       <= RESET_PC;
      pl_prev_q  <= RESET_PC[PL_WIDTH-1:0];
      level_q    <= 4'd0;
      overflow_q <= 1'b0;
      // NOTE: the stack is a handful of flops, not a RAM, so it is reset;
      // RET from an empty stack must return a defined address.
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      pl_prev_q  <= pl_prev_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      stack_q    <= stack_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.stack_top     = stack_q[0];
  assign bus.level         = level_q;
  assign bus.in_subroutine = (level_q != 4'd0);
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_unit
// Two units share one stimulus stream: dut0 (binary Pl, depth 2) and
// dut1 (polynomial Pl, depth 3). A queue-based reference model predicts the
// state after each issued op; a separate monitor compares once the result
// is due.
// ---------------------------------------------------------------------------
module tb_pc_stack_unit;
  import cpu_pc_pkg::*;

  localparam int PCW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_stack_unit_if #(.PC_WIDTH(PCW)) bus0 ();
  pc_stack_unit_if #(.PC_WIDTH(PCW)) bus1 ();

  pc_stack_unit #(
    .PC_WIDTH(PCW), .STACK_DEPTH(2), .PL_MODE(PL_MODE_BINARY), .RESET_PC('0)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  pc_stack_unit #(
    .PC_WIDTH(PCW), .STACK_DEPTH(3), .PL_MODE(PL_MODE_LFSR), .RESET_PC('0)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dut;
    int         due;
    logic [11:0] pc;
    logic [11:0] top;
    logic [3:0]  level;
    logic        insub;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  typedef logic [11:0] stk_t[$];
  int   m_pc   [2];
  int   m_prev [2];
  int   m_lvl  [2];
  bit   m_ovf  [2];
  stk_t m_ent  [2];

  function automatic int depth_of(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic model_step(int k, bit rst, bit en, int op, int addr, int imm);
    int d  = depth_of(k);
    int pl = m_pc[k] & 'h3F;
    int hi = m_pc[k] & 'hFC0;
    if (rst) begin
      m_pc[k] = 0; m_prev[k] = 0; m_lvl[k] = 0; m_ovf[k] = 1'b0;
      m_ent[k].delete();
      repeat (d) m_ent[k].push_back(12'h000);
    end else if (en) begin
      case (op)
        1: begin
          m_prev[k] = pl;
          if (k == 0) pl = (pl + 1) % 64;
          else        pl = ((((pl ^ (pl >> 1)) & 1) ^ 1) << 5) | (pl >> 1);
          m_pc[k] = hi | pl;
        end
        2: m_pc[k] = hi | imm;
        3: m_pc[k] = addr;
        4: begin
          m_ent[k].push_front(12'(m_pc[k]));
          void'(m_ent[k].pop_back());
          if (m_lvl[k] < d) m_lvl[k]++;
          else              m_ovf[k] = 1'b1;
          m_pc[k] = addr;
        end
        5: begin
          m_pc[k] = int'(m_ent[k][0]);
          m_ent[k].push_back(m_ent[k][d-1]);
          void'(m_ent[k].pop_front());
          if (m_lvl[k] > 0) m_lvl[k]--;
        end
        6: m_pc[k] = hi | (m_prev[k] & 'h30) | (imm & 'hF);
        7: m_ent[k][0] = (m_ent[k][0] & 12'hC3F) | 12'((imm & 'hF) << 6);
        default: ;
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic do_op(bit rst, bit en, int op, int addr, int imm);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    bus0.en   = en;   bus1.en   = en;
    bus0.op   = pc_op_t'(3'(op)); bus1.op = pc_op_t'(3'(op));
    bus0.addr = 12'(addr); bus1.addr = 12'(addr);
    bus0.imm  = 6'(imm);  bus1.imm  = 6'(imm);
    for (int k = 0; k < 2; k++) begin
      model_step(k, rst, en, op, addr, imm);
      e.dut   = k;
      e.due   = cyc + 1;
      e.pc    = 12'(m_pc[k]);
      e.top   = m_ent[k][0];
      e.level = 4'(m_lvl[k]);
      e.insub = (m_lvl[k] != 0);
      e.ovf   = m_ovf[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic check(string name, int dut, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d actual=0x%0h expected=0x%0h",
               name, dut, cyc, act, expv);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        check("pc",        0, 32'(bus0.pc),            32'(e.pc));
        check("stack_top", 0, 32'(bus0.stack_top),     32'(e.top));
        check("level",     0, 32'(bus0.level),         32'(e.level));
        check("in_sub",    0, 32'(bus0.in_subroutine), 32'(e.insub));
        check("overflow",  0, 32'(bus0.overflow),      32'(e.ovf));
      end else begin
        check("pc",        1, 32'(bus1.pc),            32'(e.pc));
        check("stack_top", 1, 32'(bus1.stack_top),     32'(e.top));
        check("level",     1, 32'(bus1.level),         32'(e.level));
        check("in_sub",    1, 32'(bus1.in_subroutine), 32'(e.insub));
        check("overflow",  1, 32'(bus1.overflow),      32'(e.ovf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.en = 1'b0; bus1.en = 1'b0;
    bus0.op = NOP;  bus1.op = NOP;
    bus0.addr = '0; bus1.addr = '0;
    bus0.imm  = '0; bus1.imm  = '0;

    // Pl stepping from reset: binary 1,2,3 / polynomial 0x20,0x30,0x38
    do_op(1, 0, 0, 0, 0);
    repeat (3) do_op(0, 1, 1, 0, 0);

    // nested calls and returns
    do_op(1, 0, 0, 0, 0);
    do_op(0, 1, 3, 'h105, 0);
    do_op(0, 1, 4, 'h200, 0);
    do_op(0, 1, 4, 'h300, 0);
    do_op(0, 1, 5, 0, 0);
    do_op(0, 1, 5, 0, 0);

    // overflow on depth 2, then pops past empty
    do_op(1, 0, 0, 0, 0);
    do_op(0, 1, 3, 'h010, 0); do_op(0, 1, 4, 'h400, 0);
    do_op(0, 1, 3, 'h020, 0); do_op(0, 1, 4, 'h500, 0);
    do_op(0, 1, 3, 'h030, 0); do_op(0, 1, 4, 'h600, 0);
    repeat (3) do_op(0, 1, 5, 0, 0);

    // ATPL uses the pre-step page bits
    do_op(1, 0, 0, 0, 0);
    do_op(0, 1, 2, 0, 'h1F);
    do_op(0, 1, 1, 0, 0);
    do_op(0, 1, 6, 0, 'h05);

    // SSR page field, then short jump
    do_op(1, 0, 0, 0, 0);
    do_op(0, 1, 3, 'h3C5, 0);
    do_op(0, 1, 7, 0, 'h0A);
    do_op(0, 1, 2, 0, 'h3F);

    // enable low holds state; reset beats a simultaneous CALL
    do_op(0, 0, 4, 'h777, 0);
    do_op(0, 1, 4, 'h123, 0);
    do_op(1, 1, 4, 'h456, 0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      do_op($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 63)));
    end

    @(posedge clk); #1;
    bus0.en = 1'b0; bus1.en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("drain", 0, 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
